// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing out-of-order issue queue with wakeup and squash
module issue_queue #(
  parameter int p_seq_num_bits  = 5,
  parameter int p_num_phys_regs = 36,
  parameter int p_depth         = 4,
  parameter int p_num_pipes     = 2,
  parameter int p_payload_bits  = 96
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               enq_val,
  output logic                                               enq_rdy,
  input  logic [p_seq_num_bits-1:0]                          enq_seq_num,
  input  logic [2*$clog2(p_num_phys_regs)-1:0]               enq_psrc,
  input  logic [1:0]                                         enq_pending,
  input  logic [p_num_pipes-1:0]                             enq_pipe_mask,
  input  logic [p_payload_bits-1:0]                          enq_payload,
  output logic [p_num_pipes-1:0]                             iss_val,
  input  logic [p_num_pipes-1:0]                             iss_rdy,
  output logic [p_num_pipes*p_seq_num_bits-1:0]              iss_seq_num,
  output logic [p_num_pipes*2*$clog2(p_num_phys_regs)-1:0]   iss_psrc,
  output logic [p_num_pipes*p_payload_bits-1:0]              iss_payload,
  input  logic                                               complete_val,
  input  logic [$clog2(p_num_phys_regs)-1:0]                 complete_preg,
  input  logic                                               squash_val,
  input  logic [p_seq_num_bits-1:0]                          squash_seq_num,
  output logic [$clog2(p_depth+1)-1:0]                       count
);

  localparam int pb = $clog2(p_num_phys_regs);
  localparam int cw = $clog2(p_depth + 1);

  // Entry storage; index 0 is always the oldest valid entry.
  logic [p_depth-1:0]        valid_q, valid_d;
  logic [p_seq_num_bits-1:0] seq_q     [p_depth];
  logic [p_seq_num_bits-1:0] seq_d     [p_depth];
  logic [2*pb-1:0]           psrc_q    [p_depth];
  logic [2*pb-1:0]           psrc_d    [p_depth];
  logic [1:0]                pend_q    [p_depth];
  logic [1:0]                pend_d    [p_depth];
  logic [p_num_pipes-1:0]    mask_q    [p_depth];
  logic [p_num_pipes-1:0]    mask_d    [p_depth];
  logic [p_payload_bits-1:0] payload_q [p_depth];
  logic [p_payload_bits-1:0] payload_d [p_depth];
  logic [cw-1:0]             count_q, count_d;

  logic [p_depth-1:0] ready;
  logic [p_depth-1:0] squashed;
  logic [p_depth-1:0] issued;
  logic [p_depth-1:0] keep;
  logic [p_depth-1:0] taken;
  logic [1:0]         pend_wake [p_depth];
  logic [1:0]         enq_pend_wake;
  logic               enq_fire;
  logic               enq_keep;
  logic               found;
  int                 pos [p_depth];
  int                 surv;

  // Modular age compare: s is strictly younger than ref_seq within half the number space.
  function automatic logic is_younger(input logic [p_seq_num_bits-1:0] s,
                                      input logic [p_seq_num_bits-1:0] ref_seq);
    logic [p_seq_num_bits-1:0] d;
    d = s - ref_seq;
    return (d != '0) && !d[p_seq_num_bits-1];
  endfunction

  assign count   = count_q;
  assign enq_rdy = (count_q < cw'(p_depth));
  assign enq_fire = enq_val && enq_rdy;
  assign enq_keep = enq_fire && !(squash_val && is_younger(enq_seq_num, squash_seq_num));

  // Per-entry readiness and squash mask from registered state; wakeup-adjusted pending bits.
  always_comb begin
    ready         = '0;
    squashed      = '0;
    pend_wake     = '{default: '0};
    enq_pend_wake = '0;
    for (int e = 0; e < p_depth; e++) begin
      ready[e]    = valid_q[e] && (pend_q[e] == 2'b00);
      squashed[e] = squash_val && valid_q[e] && is_younger(seq_q[e], squash_seq_num);
      for (int i = 0; i < 2; i++) begin
        pend_wake[e][i] = pend_q[e][i] &&
                          !(complete_val && (psrc_q[e][i*pb +: pb] == complete_preg));
      end
    end
    for (int i = 0; i < 2; i++) begin
      enq_pend_wake[i] = enq_pending[i] &&
                         !(complete_val && (enq_psrc[i*pb +: pb] == complete_preg));
    end
  end

  // Priority select: each pipe in turn takes the oldest ready, compatible, unclaimed entry.
  always_comb begin
    taken       = '0;
    issued      = '0;
    iss_val     = '0;
    iss_seq_num = '0;
    iss_psrc    = '0;
    iss_payload = '0;
    found       = 1'b0;
    for (int k = 0; k < p_num_pipes; k++) begin
      found = 1'b0;
      for (int e = 0; e < p_depth; e++) begin
        if (!found && ready[e] && mask_q[e][k] && !taken[e] && !squashed[e]) begin
          found      = 1'b1;
          taken[e]   = 1'b1;
          iss_val[k] = 1'b1;
          iss_seq_num[k*p_seq_num_bits +: p_seq_num_bits] = seq_q[e];
          iss_psrc[k*2*pb +: 2*pb]                        = psrc_q[e];
          iss_payload[k*p_payload_bits +: p_payload_bits] = payload_q[e];
          if (iss_rdy[k]) begin
            issued[e] = 1'b1;
          end
        end
      end
    end
  end

  // Compaction: survivors slide down in age order, the accepted enqueue lands right above them.
  always_comb begin
    keep      = '0;
    pos       = '{default: 0};
    surv      = 0;
    valid_d   = '0;
    seq_d     = '{default: '0};
    psrc_d    = '{default: '0};
    pend_d    = '{default: '0};
    mask_d    = '{default: '0};
    payload_d = '{default: '0};
    for (int e = 0; e < p_depth; e++) begin
      keep[e] = valid_q[e] && !squashed[e] && !issued[e];
      pos[e]  = surv;
      if (keep[e]) begin
        surv = surv + 1;
      end
    end
    for (int j = 0; j < p_depth; j++) begin
      for (int e = 0; e < p_depth; e++) begin
        if (keep[e] && (pos[e] == j)) begin
          valid_d[j]   = 1'b1;
          seq_d[j]     = seq_q[e];
          psrc_d[j]    = psrc_q[e];
          pend_d[j]    = pend_wake[e];
          mask_d[j]    = mask_q[e];
          payload_d[j] = payload_q[e];
        end
      end
      if (enq_keep && (surv == j)) begin
        valid_d[j]   = 1'b1;
        seq_d[j]     = enq_seq_num;
        psrc_d[j]    = enq_psrc;
        pend_d[j]    = enq_pend_wake;
        mask_d[j]    = enq_pipe_mask;
        payload_d[j] = enq_payload;
      end
    end
    count_d = cw'(surv + (enq_keep ? 1 : 0));
  end

  // Occupancy state; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Entry fields; meaningless while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    seq_q     <= seq_d;
    psrc_q    <= psrc_d;
    pend_q    <= pend_d;
    mask_q    <= mask_d;
    payload_q <= payload_d;
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking scoreboard bench for issue_queue
module tb_issue_queue;

  logic        clk;
  logic        rst;
  logic        enq_val;
  logic        enq_rdy;
  logic [4:0]  enq_seq_num;
  logic [11:0] enq_psrc;
  logic [1:0]  enq_pending;
  logic [1:0]  enq_pipe_mask;
  logic [95:0] enq_payload;
  logic [1:0]  iss_val;
  logic [1:0]  iss_rdy;
  logic [9:0]  iss_seq_num;
  logic [23:0] iss_psrc;
  logic [191:0] iss_payload;
  logic        complete_val;
  logic [5:0]  complete_preg;
  logic        squash_val;
  logic [4:0]  squash_seq_num;
  logic [2:0]  count;

  int checks;
  int failures;

  typedef struct {
    int         pipe;
    logic [4:0] seq;
  } exp_t;

  exp_t exp_q[$];

  issue_queue dut (
    .clk            (clk),
    .rst            (rst),
    .enq_val        (enq_val),
    .enq_rdy        (enq_rdy),
    .enq_seq_num    (enq_seq_num),
    .enq_psrc       (enq_psrc),
    .enq_pending    (enq_pending),
    .enq_pipe_mask  (enq_pipe_mask),
    .enq_payload    (enq_payload),
    .iss_val        (iss_val),
    .iss_rdy        (iss_rdy),
    .iss_seq_num    (iss_seq_num),
    .iss_psrc       (iss_psrc),
    .iss_payload    (iss_payload),
    .complete_val   (complete_val),
    .complete_preg  (complete_preg),
    .squash_val     (squash_val),
    .squash_seq_num (squash_seq_num),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] pay_of(input logic [4:0] s);
    return {16'hBEEF, 75'd0, s} ^ {s, 91'd12345};
  endfunction

  function automatic exp_t mk(input int p, input logic [4:0] s);
    exp_t x;
    x.pipe = p;
    x.seq  = s;
    return x;
  endfunction

  task automatic idle();
    enq_val = 0; enq_seq_num = 0; enq_psrc = 0; enq_pending = 0;
    enq_pipe_mask = 0; enq_payload = 0; complete_val = 0; complete_preg = 0;
    squash_val = 0; squash_seq_num = 0;
  endtask

  task automatic enq(input logic [4:0] s, input logic [5:0] p0, input logic [5:0] p1,
                     input logic [1:0] pend, input logic [1:0] m);
    enq_val = 1; enq_seq_num = s; enq_psrc = {p1, p0}; enq_pending = pend;
    enq_pipe_mask = m; enq_payload = pay_of(s);
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    checks++; if (iss_val !== 2'b00) begin failures++; $display("FAIL reset_iss_val got=%b exp=00", iss_val); end
    checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL reset_enq_rdy got=%b exp=1", enq_rdy); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t ex;
    iss_rdy = 2'b00;
    enq(5'd3, 6'd5, 6'd6, 2'b00, 2'b01);
    exp_q.push_back(mk(0, 5'd3));
    #1;
    checks++; if (iss_val !== 2'b00) begin failures++; $display("FAIL basic_no_bypass got=%b exp=00", iss_val); end
    @(negedge clk);
    idle();
    for (int c = 0; c < 3; c++) begin
      iss_rdy = (c == 2) ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (iss_val !== 2'b01 || iss_seq_num[4:0] !== 5'd3 || iss_psrc[11:0] !== {6'd6, 6'd5} || count !== 3'd1) begin
        failures++; $display("FAIL basic_offer c=%0d iss_val=%b seq=%0d psrc=%h count=%0d exp 01/3/185/1", c, iss_val, iss_seq_num[4:0], iss_psrc[11:0], count);
      end
      for (int k = 0; k < 2; k++) begin
        if (iss_val[k] && iss_rdy[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL basic_issue pipe%0d seq=%0d exp none", k, iss_seq_num[k*5 +: 5]);
          end else begin
            ex = exp_q.pop_front();
            if (ex.pipe != k || iss_seq_num[k*5 +: 5] !== ex.seq || iss_payload[k*96 +: 96] !== pay_of(ex.seq)) begin
              failures++; $display("FAIL basic_issue pipe%0d seq=%0d exp pipe%0d seq=%0d", k, iss_seq_num[k*5 +: 5], ex.pipe, ex.seq);
            end
          end
        end
      end
      @(negedge clk);
    end
    iss_rdy = 2'b00;
    #1;
    checks++; if (count !== 3'd0 || iss_val !== 2'b00) begin failures++; $display("FAIL basic_drained count=%0d iss_val=%b exp 0/00", count, iss_val); end
    @(negedge clk);
  endtask

  task automatic test_wakeup_ooo();
    exp_t ex;
    iss_rdy = 2'b01;
    enq(5'd1, 6'd9, 6'd1, 2'b01, 2'b01);
    #1;
    checks++; if (iss_val !== 2'b00) begin failures++; $display("FAIL ooo_empty got=%b exp=00", iss_val); end
    @(negedge clk);
    enq(5'd2, 6'd2, 6'd3, 2'b00, 2'b01);
    exp_q.push_back(mk(0, 5'd2));
    #1;
    checks++; if (iss_val !== 2'b00) begin failures++; $display("FAIL ooo_pending_blocks got=%b exp=00", iss_val); end
    @(negedge clk);
    idle();
    for (int c = 0; c < 4; c++) begin
      complete_val  = (c == 1);
      complete_preg = 6'd9;
      if (c == 1) exp_q.push_back(mk(0, 5'd1));
      #1;
      if (c == 1) begin
        checks++; if (iss_val !== 2'b00 || count !== 3'd1) begin failures++; $display("FAIL ooo_wake_same_cycle iss_val=%b count=%0d exp 00/1", iss_val, count); end
      end
      if (c == 3) begin
        checks++; if (count !== 3'd0 || iss_val !== 2'b00) begin failures++; $display("FAIL ooo_drained count=%0d iss_val=%b exp 0/00", count, iss_val); end
      end
      for (int k = 0; k < 2; k++) begin
        if (iss_val[k] && iss_rdy[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL ooo_issue pipe%0d seq=%0d exp none", k, iss_seq_num[k*5 +: 5]);
          end else begin
            ex = exp_q.pop_front();
            if (ex.pipe != k || iss_seq_num[k*5 +: 5] !== ex.seq || iss_payload[k*96 +: 96] !== pay_of(ex.seq)) begin
              failures++; $display("FAIL ooo_issue pipe%0d seq=%0d exp pipe%0d seq=%0d", k, iss_seq_num[k*5 +: 5], ex.pipe, ex.seq);
            end
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ooo_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_multi_pipe();
    exp_t ex;
    iss_rdy = 2'b00;
    for (int i = 0; i < 3; i++) begin
      enq(5'(4 + i), 6'd0, 6'd0, 2'b00, 2'b11);
      @(negedge clk);
    end
    exp_q.push_back(mk(0, 5'd4));
    exp_q.push_back(mk(1, 5'd5));
    exp_q.push_back(mk(0, 5'd6));
    idle();
    iss_rdy = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (c == 0) begin
        checks++; if (iss_val !== 2'b11) begin failures++; $display("FAIL multi_dual got=%b exp=11", iss_val); end
      end
      if (c == 1) begin
        checks++; if (iss_val !== 2'b01 || count !== 3'd1) begin failures++; $display("FAIL multi_tail iss_val=%b count=%0d exp 01/1", iss_val, count); end
      end
      if (c == 2) begin
        checks++; if (count !== 3'd0 || iss_val !== 2'b00) begin failures++; $display("FAIL multi_drained count=%0d iss_val=%b exp 0/00", count, iss_val); end
      end
      for (int k = 0; k < 2; k++) begin
        if (iss_val[k] && iss_rdy[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL multi_issue pipe%0d seq=%0d exp none", k, iss_seq_num[k*5 +: 5]);
          end else begin
            ex = exp_q.pop_front();
            if (ex.pipe != k || iss_seq_num[k*5 +: 5] !== ex.seq || iss_payload[k*96 +: 96] !== pay_of(ex.seq)) begin
              failures++; $display("FAIL multi_issue pipe%0d seq=%0d exp pipe%0d seq=%0d", k, iss_seq_num[k*5 +: 5], ex.pipe, ex.seq);
            end
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL multi_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_full();
    exp_t ex;
    iss_rdy = 2'b01;
    for (int i = 0; i < 4; i++) begin
      enq(5'(10 + i), 6'(20 + i), 6'd0, 2'b01, 2'b01);
      #1;
      checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL full_fill_rdy i=%0d got=%b exp=1", i, enq_rdy); end
      @(negedge clk);
    end
    idle();
    complete_val = 1; complete_preg = 6'd22;
    exp_q.push_back(mk(0, 5'd12));
    #1;
    checks++; if (count !== 3'd4 || enq_rdy !== 1'b0) begin failures++; $display("FAIL full_flag count=%0d enq_rdy=%b exp 4/0", count, enq_rdy); end
    @(negedge clk);
    idle();
    enq(5'd14, 6'd30, 6'd0, 2'b00, 2'b01);
    #1;
    checks++; if (enq_rdy !== 1'b0) begin failures++; $display("FAIL full_no_credit got=%b exp=0", enq_rdy); end
    for (int k = 0; k < 2; k++) begin
      if (iss_val[k] && iss_rdy[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL full_issue pipe%0d seq=%0d exp none", k, iss_seq_num[k*5 +: 5]);
        end else begin
          ex = exp_q.pop_front();
          if (ex.pipe != k || iss_seq_num[k*5 +: 5] !== ex.seq || iss_payload[k*96 +: 96] !== pay_of(ex.seq)) begin
            failures++; $display("FAIL full_issue pipe%0d seq=%0d exp pipe%0d seq=%0d", k, iss_seq_num[k*5 +: 5], ex.pipe, ex.seq);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_first_issue missing left=%0d exp=0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    iss_rdy = 2'b00;
    #1;
    checks++; if (count !== 3'd3 || enq_rdy !== 1'b1) begin failures++; $display("FAIL full_rdy_rise count=%0d enq_rdy=%b exp 3/1", count, enq_rdy); end
    @(negedge clk);
    idle();
    for (int i = 0; i < 3; i++) begin
      complete_val = 1;
      complete_preg = (i == 2) ? 6'd23 : 6'(20 + i);
      @(negedge clk);
    end
    idle();
    exp_q.push_back(mk(0, 5'd10));
    exp_q.push_back(mk(0, 5'd11));
    exp_q.push_back(mk(0, 5'd13));
    exp_q.push_back(mk(0, 5'd14));
    iss_rdy = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        if (iss_val[k] && iss_rdy[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL full_order pipe%0d seq=%0d exp none", k, iss_seq_num[k*5 +: 5]);
          end else begin
            ex = exp_q.pop_front();
            if (ex.pipe != k || iss_seq_num[k*5 +: 5] !== ex.seq || iss_payload[k*96 +: 96] !== pay_of(ex.seq)) begin
              failures++; $display("FAIL full_order pipe%0d seq=%0d exp pipe%0d seq=%0d", k, iss_seq_num[k*5 +: 5], ex.pipe, ex.seq);
            end
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0 || count !== 3'd0) begin failures++; $display("FAIL full_drained left=%0d count=%0d exp 0/0", exp_q.size(), count); exp_q.delete(); end
  endtask

  task automatic test_squash_wrap();
    exp_t ex;
    iss_rdy = 2'b00;
    enq(5'd30, 6'd24, 6'd0, 2'b01, 2'b01); @(negedge clk);
    enq(5'd31, 6'd25, 6'd0, 2'b01, 2'b01); @(negedge clk);
    enq(5'd0,  6'd1,  6'd2, 2'b00, 2'b01); @(negedge clk);
    enq(5'd1,  6'd3,  6'd4, 2'b00, 2'b01); @(negedge clk);
    enq(5'd2,  6'd5,  6'd6, 2'b00, 2'b01);
    squash_val = 1; squash_seq_num = 5'd31;
    iss_rdy = 2'b01;
    #1;
    checks++; if (count !== 3'd4 || enq_rdy !== 1'b0) begin failures++; $display("FAIL squash_full count=%0d enq_rdy=%b exp 4/0", count, enq_rdy); end
    checks++; if (iss_val !== 2'b00) begin failures++; $display("FAIL squash_mask got=%b exp=00", iss_val); end
    @(negedge clk);
    enq(5'd0, 6'd7, 6'd8, 2'b00, 2'b01);
    squash_val = 1; squash_seq_num = 5'd31;
    #1;
    checks++; if (count !== 3'd2 || iss_val !== 2'b00) begin failures++; $display("FAIL squash_removed count=%0d iss_val=%b exp 2/00", count, iss_val); end
    checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL squash_enq_rdy got=%b exp=1", enq_rdy); end
    @(negedge clk);
    idle();
    exp_q.push_back(mk(0, 5'd30));
    exp_q.push_back(mk(0, 5'd31));
    for (int c = 0; c < 4; c++) begin
      complete_val  = (c < 2);
      complete_preg = (c == 0) ? 6'd24 : 6'd25;
      #1;
      if (c == 0) begin
        checks++; if (count !== 3'd2 || iss_val !== 2'b00) begin failures++; $display("FAIL squash_enq_dropped count=%0d iss_val=%b exp 2/00", count, iss_val); end
      end
      for (int k = 0; k < 2; k++) begin
        if (iss_val[k] && iss_rdy[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL squash_issue pipe%0d seq=%0d exp none", k, iss_seq_num[k*5 +: 5]);
          end else begin
            ex = exp_q.pop_front();
            if (ex.pipe != k || iss_seq_num[k*5 +: 5] !== ex.seq || iss_payload[k*96 +: 96] !== pay_of(ex.seq)) begin
              failures++; $display("FAIL squash_issue pipe%0d seq=%0d exp pipe%0d seq=%0d", k, iss_seq_num[k*5 +: 5], ex.pipe, ex.seq);
            end
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0 || count !== 3'd0) begin failures++; $display("FAIL squash_drained left=%0d count=%0d exp 0/0", exp_q.size(), count); exp_q.delete(); end
  endtask

  task automatic test_mid_reset();
    iss_rdy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      enq(5'(20 + i), 6'd26, 6'd0, 2'b01, 2'b01);
      @(negedge clk);
    end
    enq(5'd23, 6'd0, 6'd0, 2'b00, 2'b01);
    complete_val = 1; complete_preg = 6'd26;
    rst = 1;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL midrst_before count=%0d exp=3", count); end
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    checks++; if (count !== 3'd0 || iss_val !== 2'b00 || enq_rdy !== 1'b1) begin failures++; $display("FAIL midrst_after count=%0d iss_val=%b enq_rdy=%b exp 0/00/1", count, iss_val, enq_rdy); end
    @(negedge clk);
    #1;
    checks++; if (iss_val !== 2'b00 || count !== 3'd0) begin failures++; $display("FAIL midrst_stays_empty iss_val=%b count=%0d exp 00/0", iss_val, count); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    iss_rdy = 2'b00;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_wakeup_ooo();
    test_multi_pipe();
    test_full();
    test_squash_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
